// File: rtl/de_intake_buffer_if.sv
// FE->DE latch interface: packed fetch word in, decode head fields and
// stall/debug status out. The fetch/bench side uses master; the buffer uses slave.
interface de_intake_buffer_if #(
    parameter int DBITS    = 32,
    parameter int INSTBITS = 32,
    parameter int DEPTH    = 2
);
    logic [INSTBITS+3*DBITS:0]       fe_latch_in;
    logic                            flush;
    logic                            de_ready;
    logic                            stall_to_fe;
    logic                            de_valid;
    logic [INSTBITS-1:0]             de_inst;
    logic [DBITS-1:0]                de_pc;
    logic [DBITS-1:0]                de_pcplus;
    logic [DBITS-1:0]                de_inst_count;
    logic [$clog2(DEPTH+1)-1:0]      occupancy;
    logic                            seq_err;

    modport master (
        output fe_latch_in, flush, de_ready,
        input  stall_to_fe, de_valid, de_inst, de_pc, de_pcplus,
               de_inst_count, occupancy, seq_err
    );

    modport slave (
        input  fe_latch_in, flush, de_ready,
        output stall_to_fe, de_valid, de_inst, de_pc, de_pcplus,
               de_inst_count, occupancy, seq_err
    );
endinterface

// File: rtl/de_intake_buffer.sv
// Decode-side intake queue for the FE->DE latch: in-order DEPTH-entry buffer,
// fetch stall, branch-redirect squash and inst_count continuity check.
module de_intake_buffer #(
    parameter int DBITS    = 32,
    parameter int INSTBITS = 32,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    de_intake_buffer_if.slave   bus
);
    localparam int LW = 1 + INSTBITS + 3*DBITS;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH+1);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic                w_in_valid;
    logic [INSTBITS-1:0] w_in_inst;
    logic [DBITS-1:0]    w_in_pc;
    logic [DBITS-1:0]    w_in_pcplus;
    logic [DBITS-1:0]    w_in_count;

    assign w_in_valid  = bus.fe_latch_in[LW-1];
    assign w_in_inst   = bus.fe_latch_in[LW-2 -: INSTBITS];
    assign w_in_pc     = bus.fe_latch_in[3*DBITS-1 -: DBITS];
    assign w_in_pcplus = bus.fe_latch_in[2*DBITS-1 -: DBITS];
    assign w_in_count  = bus.fe_latch_in[DBITS-1:0];

    logic [INSTBITS-1:0] r_inst   [DEPTH];
    logic [DBITS-1:0]    r_pc     [DEPTH];
    logic [DBITS-1:0]    r_pcplus [DEPTH];
    logic [DBITS-1:0]    r_count  [DEPTH];

    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [OW-1:0]    r_occ;
    logic             r_squash;
    logic             r_have_last;
    logic [DBITS-1:0] r_last;
    logic             r_seq_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Stall depends only on registered occupancy; a full queue refuses input
    // even when the head is being consumed this cycle.
    assign w_full  = (r_occ == FULL);
    assign w_empty = (r_occ == '0);
    assign w_push  = w_in_valid & ~w_full & ~bus.flush & ~r_squash;
    assign w_pop   = ~w_empty & bus.de_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_wr]   <= w_in_inst;
            r_pc[r_wr]     <= w_in_pc;
            r_pcplus[r_wr] <= w_in_pcplus;
            r_count[r_wr]  <= w_in_count;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_occ       <= '0;
            r_squash    <= 1'b0;
            r_have_last <= 1'b0;
            r_last      <= '0;
            r_seq_err   <= 1'b0;
        end else if (bus.flush) begin
            // The word after a redirect came from the sequential path, so
            // squash one more input cycle.
            r_rd        <= '0;
            r_wr        <= '0;
            r_occ       <= '0;
            r_squash    <= 1'b1;
            r_have_last <= 1'b0;
        end else begin
            r_squash <= 1'b0;
            if (w_push)
                r_wr <= r_wr + PW'(1);
            if (w_pop)
                r_rd <= r_rd + PW'(1);
            if (w_push && !w_pop)
                r_occ <= r_occ + OW'(1);
            else if (!w_push && w_pop)
                r_occ <= r_occ - OW'(1);
            if (w_push) begin
                if (r_have_last && (w_in_count != r_last + DBITS'(1)))
                    r_seq_err <= 1'b1;
                r_last      <= w_in_count;
                r_have_last <= 1'b1;
            end
        end
    end

    assign bus.stall_to_fe   = w_full;
    assign bus.de_valid      = ~w_empty;
    assign bus.de_inst       = w_empty ? '0 : r_inst[r_rd];
    assign bus.de_pc         = w_empty ? '0 : r_pc[r_rd];
    assign bus.de_pcplus     = w_empty ? '0 : r_pcplus[r_rd];
    assign bus.de_inst_count = w_empty ? '0 : r_count[r_rd];
    assign bus.occupancy     = r_occ;
    assign bus.seq_err       = r_seq_err;
endmodule

// File: tb/tb_de_intake_buffer.sv
// Directed table-driven bench for de_intake_buffer plus hand-written
// sequences for the asynchronous reset and stall-path corner cases.
module tb_de_intake_buffer;
    localparam int DBITS    = 32;
    localparam int INSTBITS = 32;
    localparam int DEPTH    = 2;

    logic clk;
    logic reset_n;

    de_intake_buffer_if #(.DBITS(DBITS), .INSTBITS(INSTBITS), .DEPTH(DEPTH)) bus ();

    de_intake_buffer #(.DBITS(DBITS), .INSTBITS(INSTBITS), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] cnt;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic        ev;
        logic [31:0] ecnt;
        logic [31:0] epc;
        logic [1:0]  eocc;
        logic        est;
        logic        eseq;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   row      = 0;

    function automatic vec_t mk(logic v, logic [31:0] cnt, logic [31:0] pc, logic fl,
                                logic rdy, logic ev, logic [31:0] ecnt, logic [31:0] epc,
                                logic [1:0] eocc, logic est, logic eseq);
        vec_t t;
        t.rst = 1'b0; t.v = v; t.cnt = cnt; t.pc = pc; t.fl = fl; t.rdy = rdy;
        t.ev = ev; t.ecnt = ecnt; t.epc = epc; t.eocc = eocc; t.est = est; t.eseq = eseq;
        return t;
    endfunction

    function automatic vec_t mk_rst();
        vec_t t;
        t = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
        t.rst = 1'b1;
        return t;
    endfunction

    function automatic logic [31:0] inst_of(logic [31:0] c);
        return 32'h1300_0000 ^ c;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [31:0] cnt, logic [31:0] pc, logic fl, logic rdy);
        bus.fe_latch_in = {v, inst_of(cnt), pc, pc + 32'd4, cnt};
        bus.flush       = fl;
        bus.de_ready    = rdy;
    endtask

    task automatic check_outputs(logic ev, logic [31:0] ecnt, logic [31:0] epc,
                                 logic [1:0] eocc, logic est, logic eseq);
        check("de_valid",      64'(bus.de_valid),      64'(ev));
        check("de_inst_count", 64'(bus.de_inst_count), 64'(ev ? ecnt : 32'd0));
        check("de_pc",         64'(bus.de_pc),         64'(ev ? epc : 32'd0));
        check("de_pcplus",     64'(bus.de_pcplus),     64'(ev ? epc + 32'd4 : 32'd0));
        check("de_inst",       64'(bus.de_inst),       64'(ev ? inst_of(ecnt) : 32'd0));
        check("occupancy",     64'(bus.occupancy),     64'(eocc));
        check("stall_to_fe",   64'(bus.stall_to_fe),   64'(est));
        check("seq_err",       64'(bus.seq_err),       64'(eseq));
    endtask

    initial begin
        reset_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Stream with de_ready=1
        vq.push_back(mk_rst());
        for (int k = 1; k <= 6; k++)
            vq.push_back(mk(1, 32'(k), 32'((k-1)*4), 0, 1, 1, 32'(k), 32'((k-1)*4), 2'd1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 0, 0));

        // Backpressure, full queue rejects even with pop, no duplicate
        vq.push_back(mk_rst());
        vq.push_back(mk(1, 1, 32'h0, 0, 0, 1, 1, 32'h0, 2'd1, 0, 0));
        vq.push_back(mk(1, 2, 32'h4, 0, 0, 1, 1, 32'h0, 2'd2, 1, 0));
        vq.push_back(mk(1, 3, 32'h8, 0, 0, 1, 1, 32'h0, 2'd2, 1, 0));
        vq.push_back(mk(1, 3, 32'h8, 0, 1, 1, 2, 32'h4, 2'd1, 0, 0));
        vq.push_back(mk(1, 3, 32'h8, 0, 1, 1, 3, 32'h8, 2'd1, 0, 0));
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 2'd0, 0, 0));
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 2'd0, 0, 0));

        // Flush drops 6 and 7; 8 starts a fresh sequence
        vq.push_back(mk_rst());
        vq.push_back(mk(1, 4, 32'hC,  0, 0, 1, 4, 32'hC,  2'd1, 0, 0));
        vq.push_back(mk(1, 5, 32'h10, 0, 0, 1, 4, 32'hC,  2'd2, 1, 0));
        vq.push_back(mk(1, 6, 32'h14, 1, 1, 0, 0, 32'h0,  2'd0, 0, 0));
        vq.push_back(mk(1, 7, 32'h18, 0, 0, 0, 0, 32'h0,  2'd0, 0, 0));
        vq.push_back(mk(1, 8, 32'h40, 0, 0, 1, 8, 32'h40, 2'd1, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 32'h0,  2'd0, 0, 0));
        // Back-to-back flushes keep squashing
        vq.push_back(mk(1, 9,  32'h44, 1, 1, 0, 0,  32'h0,  2'd0, 0, 0));
        vq.push_back(mk(1, 10, 32'h48, 1, 1, 0, 0,  32'h0,  2'd0, 0, 0));
        vq.push_back(mk(1, 11, 32'h4C, 0, 0, 0, 0,  32'h0,  2'd0, 0, 0));
        vq.push_back(mk(1, 12, 32'h50, 0, 0, 1, 12, 32'h50, 2'd1, 0, 0));
        vq.push_back(mk(0, 0,  32'h0,  0, 1, 0, 0,  32'h0,  2'd0, 0, 0));

        // Sequence error is sticky across flush, cleared by reset
        vq.push_back(mk_rst());
        vq.push_back(mk(1, 1, 32'h0, 0, 1, 1, 1, 32'h0, 2'd1, 0, 0));
        vq.push_back(mk(1, 2, 32'h4, 0, 1, 1, 2, 32'h4, 2'd1, 0, 0));
        vq.push_back(mk(1, 4, 32'hC, 0, 1, 1, 4, 32'hC, 2'd1, 0, 1));
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 2'd0, 0, 1));
        vq.push_back(mk(0, 0, 32'h0, 1, 1, 0, 0, 32'h0, 2'd0, 0, 1));
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 2'd0, 0, 1));
        vq.push_back(mk_rst());

        // Invalid gap does not disturb continuity; count wraps mod 2^32
        vq.push_back(mk(1, 1, 32'h0, 0, 1, 1, 1, 32'h0, 2'd1, 0, 0));
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 2'd0, 0, 0));
        vq.push_back(mk(1, 2, 32'h4, 0, 1, 1, 2, 32'h4, 2'd1, 0, 0));
        vq.push_back(mk_rst());
        vq.push_back(mk(1, 32'hFFFF_FFFF, 32'h100, 0, 1, 1, 32'hFFFF_FFFF, 32'h100, 2'd1, 0, 0));
        vq.push_back(mk(1, 32'h0,         32'h104, 0, 1, 1, 32'h0,         32'h104, 2'd1, 0, 0));
        vq.push_back(mk(0, 0,             32'h0,   0, 1, 0, 0,             32'h0,   2'd0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            row = i;
            if (vq[i].rst) begin
                drive(1'b0, '0, '0, 1'b0, 1'b0);
                reset_n = 1'b0;
                #2;
                check_outputs(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
                reset_n = 1'b1;
            end else begin
                drive(vq[i].v, vq[i].cnt, vq[i].pc, vq[i].fl, vq[i].rdy);
                @(posedge clk);
                #1;
                check_outputs(vq[i].ev, vq[i].ecnt, vq[i].epc, vq[i].eocc, vq[i].est, vq[i].eseq);
            end
        end

        // Full queue: stall must not react combinationally to de_ready/flush,
        // then an asynchronous reset clears everything between edges.
        row = 1000;
        drive(1'b1, 32'd1, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'd2, 32'h4, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs(1'b1, 32'd1, 32'h0, 2'd2, 1'b1, 1'b0);
        row = 1001;
        drive(1'b1, 32'd3, 32'h8, 1'b1, 1'b1);
        #1;
        check("stall_comb_path", 64'(bus.stall_to_fe), 64'(1'b1));
        check("occ_comb_path",   64'(bus.occupancy),   64'(2'd2));
        row = 1002;
        reset_n = 1'b0;
        #1;
        check_outputs(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        row = 1003;
        check_outputs(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/de_intake_buffer.md
Name: de_intake_buffer

Overview:
- Receiving end of the FE->DE pipeline latch.
- Unpacks the FE latch word {valid, inst, pc, pcplus, inst_count} into a DEPTH-entry in-order queue that feeds the decode logic.
- Generates the stall back to the fetch stage and squashes wrong-path entries on an AGEX branch redirect.
- Tracks inst_count continuity as a debug check.

Parameters:
- DBITS, 32, width of the pc, pcplus and inst_count fields
- INSTBITS, 32, instruction width
- DEPTH, 2, queue entries (>=2, power of two)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous active-low reset
- fe_latch_in  in  1+INSTBITS+3*DBITS  packed {valid(MSB), inst, pc, pcplus, inst_count(LSBs)}
- flush  in  1  branch taken in AGEX this cycle
- de_ready  in  1  decode can consume the head entry this cycle
- stall_to_fe  out  1  fetch must hold PC and latch; the input this cycle is not captured
- de_valid  out  1  head entry valid
- de_inst  out  INSTBITS  head instruction
- de_pc  out  DBITS  head PC
- de_pcplus  out  DBITS  head PC+4
- de_inst_count  out  DBITS  head debug counter
- occupancy  out  clog2(DEPTH+1)  entries held
- seq_err  out  1  sticky inst_count discontinuity flag

Behaviour:
- Reset (reset_n low, asynchronous): queue empty, read/write pointers 0, squash_next=0, have_last=0, seq_err=0.
  - All outputs read 0: de_valid=0, stall_to_fe=0, occupancy=0, data outputs 0.
- stall_to_fe = (occupancy==DEPTH), decoded from registered state only. There is no combinational path from de_ready or flush.
- Push condition: in_valid & !stall_to_fe & !flush & !squash_next.
  - A rejected input is not lost: fetch re-presents it, because it held its latch.
- Pop condition: de_valid & de_ready & !flush.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance.
  - When full, push is rejected even if a pop occurs (pop-through is not supported).
- Pointers wrap modulo DEPTH.
- Head fields are driven combinationally from the entry at the read pointer. Data outputs are 0 when the queue is empty.
- Latency: an entry pushed at edge N is visible on de_* after edge N (one cycle after presentation).
- flush=1 at edge N:
  - Queue emptied.
  - Input at N discarded.
  - Pop suppressed.
  - squash_next<=1, which discards the input presented in cycle N+1: that word was fetched from the sequential path.
  - have_last<=0.
- squash_next clears after one cycle unless flush is reasserted. Back-to-back flushes keep squashing.
- Sequence check on each push:
  - If have_last=1 and inst_count != last_count+1 (mod 2^DBITS), set seq_err.
  - Then last_count<=inst_count and have_last<=1.
  - seq_err clears only on reset.
- Reset mid-operation: everything returns immediately to the reset state; no entry survives.
- Input valid=0 is never pushed and does not disturb the sequence check.

Test Plan:
- Stream: after reset, present inst_count 1..6 (pc 0x0,0x4,...) with de_ready=1 -> each appears on de_* one cycle later in order; occupancy stays <=1; stall_to_fe never asserts; seq_err=0.
- Backpressure: de_ready=0, present counts 1,2,3 -> occupancy 2 and stall_to_fe=1 from the cycle after the second push; count 3 held by the bench. Raise de_ready -> 1,2,3 delivered exactly once, no duplicate.
- Simultaneous push/pop: occupancy=1, de_ready=1, valid input -> occupancy stays 1 and the head advances to the new entry next cycle.
- Flush: queue holds counts 4,5; assert flush with count 6 on the input, then present 7, then 8 (pc 0x40) -> queue empty, 6 and 7 dropped, 8 accepted, seq_err stays 0.
- Sequence error: push counts 1,2 then 4 -> seq_err=1 after the push of 4 and remains set; a later flush does not clear it; reset_n pulse clears it.
- Async reset mid-stream: drop reset_n between clock edges with occupancy=2 -> de_valid, occupancy and stall_to_fe go to 0 without a clock edge.
